wb_stage: RTL

Writeback stage of the bulbul core: merges the single-cycle ALU result path and in-order data-memory load responses into the register file's single write port (regwrite, rd, write data). Loads are tracked in a small in-order load queue holding destination register, funct3 and byte offset, so returned words are extracted and sign- or zero-extended here. A pending-destination scoreboard is exported to decode for load-use stalls.

---
 rtl/wb_stage_if.sv | 35 +++
 rtl/wb_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/wb_stage_if.sv
// Writeback-stage bus: ALU result path, load issue, data-memory response and
// register-file write port, plus the pending-destination scoreboard.
interface wb_stage_if;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_result_i;
  logic        ld_req_valid_i;
  logic        ld_req_ready_o;
  logic [4:0]  ld_rd_i;
  logic [2:0]  ld_funct3_i;
  logic [1:0]  ld_addr_lo_i;
  logic        dmem_rvalid_i;
  logic        dmem_rready_o;
  logic [31:0] dmem_rdata_i;
  logic        regwrite_o;
  logic [4:0]  rd_o;
  logic [31:0] wd_o;
  logic [31:0] busy_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_result_i,
    input  ld_req_valid_i, ld_rd_i, ld_funct3_i, ld_addr_lo_i,
    input  dmem_rvalid_i, dmem_rdata_i,
    output ld_req_ready_o, dmem_rready_o,
    output regwrite_o, rd_o, wd_o, busy_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_result_i,
    output ld_req_valid_i, ld_rd_i, ld_funct3_i, ld_addr_lo_i,
    output dmem_rvalid_i, dmem_rdata_i,
    input  ld_req_ready_o, dmem_rready_o,
    input  regwrite_o, rd_o, wd_o, busy_o
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates ALU results against in-order load responses onto
// the single register-file write port and exports a pending-write scoreboard.
module wb_stage #(
  parameter int LQ_DEPTH = 2
) (
  input logic       clk_i,
  input logic       reset_i,
  wb_stage_if.slave bus
);
  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = $clog2(LQ_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(LQ_DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;

  logic [4:0] ent_rd_q  [LQ_DEPTH];
  logic [2:0] ent_f3_q  [LQ_DEPTH];
  logic [1:0] ent_off_q [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] ent_vld_q;

  logic        regwrite_q, regwrite_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wd_q, wd_d;

  logic        ld_ready, rsp_ready, push, pop;
  logic [4:0]  head_rd;
  logic [2:0]  head_f3;
  logic [1:0]  head_off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] busy_vec;

  // ALU results always win the write port; responses only fill idle cycles.
  assign ld_ready  = (count_q != FULL_CNT);
  assign rsp_ready = !bus.alu_valid_i && (count_q != '0);
  assign push      = bus.ld_req_valid_i && ld_ready;
  assign pop       = bus.dmem_rvalid_i && rsp_ready;

  assign head_rd  = ent_rd_q[rptr_q];
  assign head_f3  = ent_f3_q[rptr_q];
  assign head_off = ent_off_q[rptr_q];

  always_comb begin
    ld_byte = bus.dmem_rdata_i[{head_off, 3'b000} +: 8];
    ld_half = bus.dmem_rdata_i[{head_off[1], 4'b0000} +: 16];
    case (head_f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = bus.dmem_rdata_i;
    endcase
  end

  always_comb begin
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Writes to x0 still update rd/wd so the port looks uniform; only the enable drops.
  always_comb begin
    regwrite_d = 1'b0;
    rd_d       = rd_q;
    wd_d       = wd_q;
    if (bus.alu_valid_i) begin
      regwrite_d = (bus.alu_rd_i != 5'd0);
      rd_d       = bus.alu_rd_i;
      wd_d       = bus.alu_result_i;
    end else if (pop) begin
      regwrite_d = (head_rd != 5'd0);
      rd_d       = head_rd;
      wd_d       = ld_data;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wd_q       <= '0;
    end else begin
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wd_q       <= wd_d;
    end
  end

  generate
    for (genvar gi = 0; gi < LQ_DEPTH; gi++) begin : g_ent
      logic       vld_d;
      logic [4:0] rd_e_d;
      logic [2:0] f3_e_d;
      logic [1:0] off_e_d;

      always_comb begin
        vld_d   = ent_vld_q[gi];
        rd_e_d  = ent_rd_q[gi];
        f3_e_d  = ent_f3_q[gi];
        off_e_d = ent_off_q[gi];
        if (pop && rptr_q == PW'(gi)) begin
          vld_d = 1'b0;
        end
        if (push && wptr_q == PW'(gi)) begin
          vld_d   = 1'b1;
          rd_e_d  = bus.ld_rd_i;
          f3_e_d  = bus.ld_funct3_i;
          off_e_d = bus.ld_addr_lo_i;
        end
      end

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          ent_vld_q[gi] <= 1'b0;
          ent_rd_q[gi]  <= '0;
          ent_f3_q[gi]  <= '0;
          ent_off_q[gi] <= '0;
        end else begin
          ent_vld_q[gi] <= vld_d;
          ent_rd_q[gi]  <= rd_e_d;
          ent_f3_q[gi]  <= f3_e_d;
          ent_off_q[gi] <= off_e_d;
        end
      end
    end

    // A register stays busy until the cycle after its write is presented.
    for (genvar gi = 0; gi < 32; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_vec[gi] = 1'b0;
      end else begin : g_reg
        logic hit;
        always_comb begin
          hit = regwrite_q && (rd_q == 5'(gi));
          for (int e = 0; e < LQ_DEPTH; e++) begin
            if (ent_vld_q[e] && ent_rd_q[e] == 5'(gi)) begin
              hit = 1'b1;
            end
          end
        end
        assign busy_vec[gi] = hit;
      end
    end
  endgenerate

  assign bus.ld_req_ready_o = ld_ready;
  assign bus.dmem_rready_o  = rsp_ready;
  assign bus.regwrite_o     = regwrite_q;
  assign bus.rd_o           = rd_q;
  assign bus.wd_o           = wd_q;
  assign bus.busy_o         = busy_vec;
endmodule
